// File: rtl/ahb_slave_image_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_image_mem
//
// AHB-Lite responder holding 32-bit image pixel words for the edge-detection
// datapath. Address and data phases are pipelined. A fixed number of wait
// states can be inserted in every OKAY data phase. Illegal transfers get the
// standard two-cycle ERROR response. A sideband preload port lets an image be
// loaded without bus traffic. wr_count reports how many AHB writes completed.
//
// Parameters
//   ADDR_W       HADDR width in bits (byte address)
//   DEPTH        memory depth in 32-bit words; DEPTH >= 2 and DEPTH*4 <= 2**ADDR_W
//   WAIT_STATES  HREADYOUT-low cycles per OKAY data phase, 0..7
//
// Ports
//   HCLK       in   clock, all logic on the rising edge
//   HRESET     in   synchronous reset, active-high
//   HSEL       in   slave select
//   HADDR      in   byte address
//   HWRITE     in   1 = write, 0 = read
//   HTRANS     in   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   HSIZE      in   only 3'b010 (word) is legal
//   HWDATA     in   write data, valid in the write data phase
//   HREADY     in   bus-level ready; an address phase is taken only when high
//   HRDATA     out  read data, zero outside a data phase
//   HREADYOUT  out  slave ready; low while waiting or in the first ERROR cycle
//   HRESP      out  0 OKAY, 1 ERROR
//   load_en    in   preload strobe
//   load_addr  in   preload word index
//   load_data  in   preload word
//   wr_count   out  completed OKAY AHB writes, wraps at 16 bits
// ---------------------------------------------------------------------------
module ahb_slave_image_mem #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [ADDR_W-1:0]        HADDR,
    input  logic                     HWRITE,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HSIZE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic [15:0]              wr_count
);

    localparam int                IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH);
    localparam logic [IDX_W:0]    DEPTH_IDX   = (IDX_W + 1)'(DEPTH);
    localparam logic [2:0]        WAIT_LOAD   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [2:0]        HSIZE_WORD  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [2:0]        wait_cnt_q;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              can_accept;
    logic              take;
    logic [ADDR_W-1:0] word_addr;
    logic              addr_err;
    logic              commit;
    logic              load_ok;

    // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
    logic unused_htrans;
    assign unused_htrans = HTRANS[0];

    // A new address phase may only be taken in cycles where HREADYOUT is high.
    assign accept     = HSEL & HREADY & HTRANS[1];
    assign can_accept = (state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2);
    assign take       = accept & can_accept;

    // Word address is widened back to ADDR_W so DEPTH = 2**(ADDR_W-2) still compares correctly.
    assign word_addr = {2'b00, HADDR[ADDR_W-1:2]};
    assign addr_err  = (HSIZE != HSIZE_WORD) | (HADDR[1:0] != 2'b00) | (word_addr >= DEPTH_WORDS);

    // A write lands at the edge that ends its DATA cycle; reset on that edge abandons it.
    assign commit  = (state_q == S_DATA) & write_q & ~HRESET;
    assign load_ok = load_en & ({1'b0, load_addr} < DEPTH_IDX);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                if (take) begin
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = S_DATA;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'd0;
        case (state_q)
            S_WAIT: HREADYOUT = 1'b0;
            S_DATA: HRDATA    = mem[idx_q];
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP     = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Transfer context, wait counter and write counter
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            idx_q      <= '0;
            write_q    <= 1'b0;
            wait_cnt_q <= 3'd0;
            wr_count   <= 16'd0;
        end else begin
            if (take) begin
                idx_q   <= HADDR[IDX_W+1:2];
                write_q <= HWRITE;
            end

            if (take & ~addr_err) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if ((state_q == S_WAIT) && (wait_cnt_q != 3'd0)) begin
                wait_cnt_q <= wait_cnt_q - 3'd1;
            end

            if (commit) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pixel memory: one write port shared by the bus and the preload port
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset; image data survives HRESET and a reset
    // loop over DEPTH words would block RAM inference.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            mem[idx_q] <= HWDATA;
        end else if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_ahb_slave_image_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_image_mem
//
// Directed bench for ahb_slave_image_mem. Two instances are built, one with
// zero wait states and one with two; the sel variable routes the bus to one
// of them. Each slave's HREADYOUT is fed back as its HREADY, as in a
// single-slave system. Inputs are driven and outputs sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_ahb_slave_image_mem;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1024;
    localparam int IDX_W  = 10;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] SZ_WORD  = 3'b010;
    localparam logic [2:0] SZ_HALF  = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic              hreset;
    logic              sel;
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic              load_en;
    logic [IDX_W-1:0]  load_addr;
    logic [31:0]       load_data;

    // Per-instance outputs
    logic [31:0] hrdata_0, hrdata_2;
    logic        hreadyout_0, hreadyout_2;
    logic        hresp_0, hresp_2;
    logic [15:0] wr_count_0, wr_count_2;

    // Observed values of the selected instance
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [15:0] wr_count;

    assign hrdata    = sel ? hrdata_2    : hrdata_0;
    assign hreadyout = sel ? hreadyout_2 : hreadyout_0;
    assign hresp     = sel ? hresp_2     : hresp_0;
    assign wr_count  = sel ? wr_count_2  : wr_count_0;

    ahb_slave_image_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .HCLK      (clk),
        .HRESET    (hreset),
        .HSEL      (hsel & ~sel),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HTRANS    (htrans),
        .HSIZE     (hsize),
        .HWDATA    (hwdata),
        .HREADY    (hreadyout_0),
        .HRDATA    (hrdata_0),
        .HREADYOUT (hreadyout_0),
        .HRESP     (hresp_0),
        .load_en   (load_en & ~sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .wr_count  (wr_count_0)
    );

    ahb_slave_image_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
        .HCLK      (clk),
        .HRESET    (hreset),
        .HSEL      (hsel & sel),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HTRANS    (htrans),
        .HSIZE     (hsize),
        .HWDATA    (hwdata),
        .HREADY    (hreadyout_2),
        .HRDATA    (hrdata_2),
        .HREADYOUT (hreadyout_2),
        .HRESP     (hresp_2),
        .load_en   (load_en & sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .wr_count  (wr_count_2)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = T_IDLE;
        hwrite = 1'b0;
        haddr  = '0;
        hsize  = SZ_WORD;
    endtask

    task automatic addr_phase(input logic w, input logic [ADDR_W-1:0] a,
                              input logic [1:0] t, input logic [2:0] sz);
        hsel   = 1'b1;
        hwrite = w;
        haddr  = a;
        htrans = t;
        hsize  = sz;
    endtask

    // Bounded wait for the data phase to finish, then check it is OKAY.
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 10 && hreadyout == 1'b0; i++) tick();
        check({tag, "_rdy"}, 32'(hreadyout), 32'd1);
        check({tag, "_resp"}, 32'(hresp), 32'd0);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input string tag);
        addr_phase(1'b1, a, T_NONSEQ, SZ_WORD);
        tick();
        bus_idle();
        hwdata = d;
        wait_ready(tag);
        tick();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
        addr_phase(1'b0, a, T_NONSEQ, SZ_WORD);
        tick();
        bus_idle();
        wait_ready(tag);
        check({tag, "_data"}, hrdata, exp);
        tick();
    endtask

    task automatic do_err(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [2:0] sz, input string tag);
        addr_phase(w, a, T_NONSEQ, sz);
        tick();
        bus_idle();
        check({tag, "_e1_rdy"},  32'(hreadyout), 32'd0);
        check({tag, "_e1_resp"}, 32'(hresp),     32'd1);
        check({tag, "_e1_data"}, hrdata,         32'd0);
        tick();
        check({tag, "_e2_rdy"},  32'(hreadyout), 32'd1);
        check({tag, "_e2_resp"}, 32'(hresp),     32'd1);
        tick();
        check({tag, "_idle_rdy"},  32'(hreadyout), 32'd1);
        check({tag, "_idle_resp"}, 32'(hresp),     32'd0);
    endtask

    logic [31:0] wv [4];

    initial begin
        wv[0] = 32'h1111_0000;
        wv[1] = 32'h2222_0001;
        wv[2] = 32'h3333_0002;
        wv[3] = 32'h4444_0003;

        hreset    = 1'b1;
        sel       = 1'b0;
        hwdata    = 32'd0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 32'd0;
        bus_idle();
        tick();
        tick();
        hreset = 1'b0;
        tick();

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("rst%0d_rdy", s),   32'(hreadyout), 32'd1);
            check($sformatf("rst%0d_resp", s),  32'(hresp),     32'd0);
            check($sformatf("rst%0d_data", s),  hrdata,         32'd0);
            check($sformatf("rst%0d_wrcnt", s), 32'(wr_count),  32'd0);
        end
        sel = 1'b0;
        tick();

        // T1: preload then single read, zero wait states
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = 32'hA5A5_0001;
        tick();
        load_addr = 10'd0;
        load_data = 32'h0000_5A5A;
        tick();
        load_en = 1'b0;
        do_read(16'h0014, 32'hA5A5_0001, "t1_rd");
        check("t1_idle_data", hrdata, 32'd0);

        // T3: unaligned read, out-of-range write, illegal size
        do_err(1'b0, 16'h1002, SZ_WORD, "t3_unal");
        hwdata = 32'hBAD0_BAD0;
        do_err(1'b1, 16'(DEPTH * 4), SZ_WORD, "t3_oor");
        do_err(1'b0, 16'h0014, SZ_HALF, "t3_size");
        check("t3_wrcnt", 32'(wr_count), 32'd0);
        do_read(16'h0000, 32'h0000_5A5A, "t3_mem0");

        // T4: four back-to-back writes then four back-to-back reads
        for (int n = 0; n < 9; n++) begin
            if (n < 4)      addr_phase(1'b1, 16'(n * 4), (n == 0) ? T_NONSEQ : T_SEQ, SZ_WORD);
            else if (n < 8) addr_phase(1'b0, 16'((n - 4) * 4), (n == 4) ? T_NONSEQ : T_SEQ, SZ_WORD);
            else            bus_idle();
            if (n >= 1 && n <= 4) hwdata = wv[n-1];
            if (n >= 1) check($sformatf("t4_rdy%0d", n), 32'(hreadyout), 32'd1);
            if (n >= 5) check($sformatf("t4_rd%0d", n - 5), hrdata, wv[n-5]);
            if (n == 5) check("t4_wrcnt", 32'(wr_count), 32'd4);
            tick();
        end

        // Last legal word
        do_write(16'h0FFC, 32'h0F0F_F0F0, "last_wr");
        do_read(16'h0FFC, 32'h0F0F_F0F0, "last_rd");
        check("last_wrcnt", 32'(wr_count), 32'd5);

        // T5a: preload and AHB write commit to word 3 on the same edge
        addr_phase(1'b1, 16'h000C, T_NONSEQ, SZ_WORD);
        tick();
        addr_phase(1'b0, 16'h000C, T_NONSEQ, SZ_WORD);
        hwdata    = 32'h0000_1234;
        load_en   = 1'b1;
        load_addr = 10'd3;
        load_data = 32'hFFFF_0000;
        tick();
        load_en = 1'b0;
        bus_idle();
        check("t5_data",  hrdata,         32'h0000_1234);
        check("t5_wrcnt", 32'(wr_count),  32'd6);
        tick();

        // T6: BUSY with HSEL high is ignored
        addr_phase(1'b1, 16'h0000, T_BUSY, SZ_WORD);
        hwdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("t6_rdy%0d", i),   32'(hreadyout), 32'd1);
            check($sformatf("t6_resp%0d", i),  32'(hresp),     32'd0);
            check($sformatf("t6_data%0d", i),  hrdata,         32'd0);
            check($sformatf("t6_wrcnt%0d", i), 32'(wr_count),  32'd6);
        end
        bus_idle();
        do_read(16'h0000, 32'h1111_0000, "t6_mem0");

        // T2: two wait states, write then read held during the waits
        sel = 1'b1;
        tick();
        addr_phase(1'b1, 16'h0020, T_NONSEQ, SZ_WORD);
        tick();
        addr_phase(1'b0, 16'h0020, T_NONSEQ, SZ_WORD);
        hwdata = 32'hDEAD_BEEF;
        for (int n = 1; n <= 6; n++) begin
            check($sformatf("t2_rdy%0d", n), 32'(hreadyout), (n == 3 || n == 6) ? 32'd1 : 32'd0);
            check($sformatf("t2_resp%0d", n), 32'(hresp), 32'd0);
            if (n == 4) begin
                bus_idle();
                check("t2_wrcnt", 32'(wr_count), 32'd1);
            end
            if (n == 6) check("t2_data", hrdata, 32'hDEAD_BEEF);
            tick();
        end
        check("t2_idle_data", hrdata, 32'd0);

        // T5b: reset during a write wait state abandons the write
        addr_phase(1'b1, 16'h0020, T_NONSEQ, SZ_WORD);
        tick();
        bus_idle();
        hwdata = 32'h5555_AAAA;
        check("t5r_wait_rdy", 32'(hreadyout), 32'd0);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check("t5r_rdy",   32'(hreadyout), 32'd1);
        check("t5r_resp",  32'(hresp),     32'd0);
        check("t5r_data",  hrdata,         32'd0);
        check("t5r_wrcnt", 32'(wr_count),  32'd0);
        tick();
        check("t5r_idle_rdy", 32'(hreadyout), 32'd1);
        do_read(16'h0020, 32'hDEAD_BEEF, "t5r_mem");
        check("t5r_wrcnt2", 32'(wr_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
